// File: rtl/reg_dump.sv
// Register-file dump engine: walks every register through a dedicated read port
// and streams each value with its address tag over a valid/ready interface.
module reg_dump #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic         core_done,
  output logic [D-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         start_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [D-1:0] PTR_ZERO = {D{1'b0}};
  localparam logic [D-1:0] PTR_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [D-1:0] PTR_MAX  = {D{1'b1}};
  localparam logic [W-1:0] DATA_ZERO = {W{1'b0}};

  state_t         state_r;
  logic [D-1:0]   ptr_r;
  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic [D-1:0]   out_addr_r;
  logic           out_last_r;
  logic           busy_r;
  logic           done_r;
  logic           start_err_r;

  logic           accept_s;
  logic           load_s;
  logic           at_max_s;

  // Handshake and load qualifiers for the single-entry output register
  always_comb begin
    accept_s = out_valid_r && out_ready;
    load_s   = (state_r == RUN) && (!out_valid_r || out_ready);
    at_max_s = (ptr_r == PTR_MAX);
  end

  // Dump sequencer with registered stream and status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      ptr_r       <= PTR_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_addr_r  <= PTR_ZERO;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          ptr_r       <= PTR_ZERO;
          if (start && core_done) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else if (start) begin
            start_err_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (load_s) begin
            out_data_r  <= rd_data;
            out_addr_r  <= ptr_r;
            out_last_r  <= at_max_s;
            out_valid_r <= 1'b1;
            // The pointer parks on the last index so it never wraps mid-dump
            if (at_max_s) begin
              state_r <= DRAIN;
            end else begin
              ptr_r <= ptr_r + PTR_ONE;
            end
          end else if (accept_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        DRAIN: begin
          if (accept_s) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          ptr_r   <= PTR_ZERO;
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          ptr_r       <= PTR_ZERO;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr   = ptr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign start_err = start_err_r;

endmodule

// File: doc/reg_dump.md
# reg_dump

Register-file dump engine for the accumulator core: once the program has finished, it reads every register in the register file, in order, through a dedicated combinational read port. Each value goes out on a valid/ready stream with its address tag, so the test harness or a debug UART can collect final machine state. It sits beside the register file in the top level and drives that file's second read address.

## Interface
- W, 8, data path width (register width)
- D, 4, register pointer width; 2**D registers are dumped
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- start  input  1  request a dump; sampled on rising edge
- core_done  input  1  core halted; register file is not being written
- rd_addr  output  D  read address to the register file's dump read port
- rd_data  input  W  combinational read data for rd_addr, valid in the same cycle
- out_valid  output  1  out_data/out_addr/out_last hold a word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at an edge
- out_data  output  W  register value
- out_addr  output  D  register index of out_data
- out_last  output  1  current word is register 2**D-1
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse: final word accepted
- start_err  output  1  one-cycle pulse: start rejected because core_done=0

## Operation
- State machine states: IDLE, RUN, DRAIN, DONE. The pointer ptr is D bits wide. There is a single-entry output register (out_*).
- IDLE: start && core_done at an edge -> RUN, ptr=0. start && !core_done -> stay IDLE, start_err=1 for the next cycle.
- start is ignored in RUN, DRAIN and DONE. It does not raise start_err.
- rd_addr = ptr, a registered value. It is 0 in IDLE.
- Load condition in RUN: out register empty (!out_valid), or being drained this edge (out_valid && out_ready).
- On load:
  - out_data <= rd_data, out_addr <= ptr, out_last <= (ptr == 2**D-1), out_valid <= 1.
  - If ptr == 2**D-1, go to DRAIN. Otherwise ptr <= ptr+1.
- No load in RUN with out_valid && out_ready: out_valid <= 0.
- out_valid && !out_ready: out_data, out_addr and out_last are held stable. Nothing is dropped or duplicated.
- DRAIN: when the last word is accepted, out_valid <= 0 and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ptr returns to 0.
- busy = (state == RUN || state == DRAIN).
- ptr never wraps within a dump. Exactly 2**D words are produced, with addresses 0..2**D-1 in increasing order.
- core_done falling mid-dump has no effect. The dump completes, and the top level guarantees no register writes while busy.

## Timing
- Reset values: state IDLE, ptr 0, rd_addr 0, out_valid 0, out_data 0, out_addr 0, out_last 0, busy 0, done 0, start_err 0.
- Reset mid-dump aborts immediately (asynchronous). No partial word remains valid after reset deasserts.
- Edge numbering: start is accepted at edge E0, so busy=1 after E0.
- Word i is captured from rd_data at the edge where ptr==i. The earliest such edge is E(i+1).
- Latency with out_ready=1 continuously:
  - word i is valid after E(i+1) and accepted at E(i+2);
  - the last word (i=2**D-1) is accepted at E(2**D+1), where DONE is entered;
  - done=1 in the cycle after E(2**D+1);
  - busy=0 after E(2**D+1);
  - IDLE after E(2**D+2).
- Throughput is one word per cycle while out_ready=1. There are no bubbles between words.
- Back-to-back dumps: start is honored at the edge that leaves DONE only if the state is IDLE at that edge, i.e. one cycle after done.

## Test plan
- Full dump, D=4, regs preloaded with reg[i]=8'hA0+i, core_done=1, out_ready=1, start pulse at E0:
  - 16 words, addresses 0..15, data A0..AF on consecutive cycles;
  - out_last only on addr 15;
  - done pulse in the cycle after E17.
- Backpressure, out_ready toggling 1,0,1,0…:
  - out_data and out_addr stable while stalled;
  - all 16 words delivered in order exactly once;
  - done 1 cycle after the final handshake.
- Rejected start, core_done=0 with a start pulse:
  - start_err pulses for 1 cycle;
  - busy, out_valid and done stay 0;
  - rd_addr stays 0.
- Start during busy, second start pulse after word 3 is emitted:
  - ignored;
  - exactly 16 words, no restart.
- Reset mid-dump: RST_N low for 1 cycle after word 5 is valid:
  - all outputs return to reset values asynchronously;
  - a new start then dumps from addr 0.
- Small configuration, D=2, out_ready=1:
  - 4 words, addresses 0..3;
  - out_last on addr 3;
  - busy high for exactly 5 cycles.
